// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and defaults for the data-memory request path.
package uarch_pkg;

  localparam int unsigned STORE_BUF_DEPTH_DEFAULT = 4;
  localparam int unsigned STARVE_LIMIT_DEFAULT    = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  rob_idx;
  } instruction_t;

  typedef enum logic [0:0] {
    LD_PRI,
    ST_FORCE
  } arb_state_e;

endpackage

// File: rtl/dmem_req_arbiter_if.sv
// Load, committed-store and DMEM request channels plus store-drain status.
interface dmem_req_arbiter_if;
  import uarch_pkg::*;

  logic         ld_req_val;
  instruction_t ld_req_packet;
  logic         ld_req_rdy;

  logic         st_req_val;
  instruction_t st_req_packet;
  logic         st_req_rdy;

  logic         dmem_req_val;
  instruction_t dmem_req_packet;
  logic         dmem_req_is_store;
  logic         dmem_req_rdy;

  logic         st_buf_empty;

  // Arbiter side.
  modport slave (
    input  ld_req_val, ld_req_packet, st_req_val, st_req_packet, dmem_req_rdy,
    output ld_req_rdy, st_req_rdy, dmem_req_val, dmem_req_packet, dmem_req_is_store,
           st_buf_empty
  );

  // LSQ / memory side.
  modport master (
    output ld_req_val, ld_req_packet, st_req_val, st_req_packet, dmem_req_rdy,
    input  ld_req_rdy, st_req_rdy, dmem_req_val, dmem_req_packet, dmem_req_is_store,
           st_buf_empty
  );

endinterface

// File: rtl/store_buffer.sv
// Committed-store FIFO, oldest entry at head. DEPTH must be a power of two, at least 2.
module store_buffer
  import uarch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  instruction_t    push_data,
  input  logic            pop,
  output instruction_t    head,
  output logic [CntW-1:0] count
);

  instruction_t    mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dmem_req_arbiter.sv
// Arbitrates LSQ loads and buffered committed stores onto a single registered DMEM port,
// with load priority and a starvation escape that forces stores out.
module dmem_req_arbiter
  import uarch_pkg::*;
#(
  parameter int unsigned STORE_BUF_DEPTH = STORE_BUF_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  dmem_req_arbiter_if.slave bus
);

  localparam int unsigned CntW    = $clog2(STORE_BUF_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]    Full      = CntW'(STORE_BUF_DEPTH);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_e         state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               out_val_q, out_val_d;
  logic               out_is_store_q, out_is_store_d;
  instruction_t       out_pkt_q, out_pkt_d;

  logic [CntW-1:0] st_count, st_count_d;
  instruction_t    st_head;
  logic            st_push, st_avail, can_load, ld_grant, st_grant;

  store_buffer #(
    .DEPTH(STORE_BUF_DEPTH)
  ) u_store_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (st_push),
    .push_data(bus.st_req_packet),
    .pop      (st_grant),
    .head     (st_head),
    .count    (st_count)
  );

  assign st_avail = (st_count != '0);
  assign can_load = !out_val_q || bus.dmem_req_rdy;

  // Ready outputs are gated by rst so they read low while reset is held.
  assign bus.ld_req_rdy = rst && (state_q == LD_PRI) && !flush && can_load;
  assign bus.st_req_rdy = rst && (st_count < Full);

  assign st_push    = bus.st_req_val && bus.st_req_rdy;
  assign ld_grant   = bus.ld_req_val && bus.ld_req_rdy;
  assign st_grant   = can_load && st_avail && !ld_grant;
  assign st_count_d = st_count + CntW'(st_push) - CntW'(st_grant);

  always_comb begin
    out_val_d      = out_val_q;
    out_pkt_d      = out_pkt_q;
    out_is_store_d = out_is_store_q;
    if (ld_grant) begin
      out_val_d      = 1'b1;
      out_pkt_d      = bus.ld_req_packet;
      out_is_store_d = 1'b0;
    end else if (st_grant) begin
      out_val_d      = 1'b1;
      out_pkt_d      = st_head;
      out_is_store_d = 1'b1;
    end else if (out_val_q && (bus.dmem_req_rdy || (flush && !out_is_store_q))) begin
      // Either issued, or a stalled load killed by flush.
      out_val_d      = 1'b0;
      out_is_store_d = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (st_grant || !st_avail) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + StarveW'(1);
    end

    state_d = state_q;
    unique case (state_q)
      LD_PRI: begin
        if ((starve_d == StarveMax) || (st_count_d == Full)) state_d = ST_FORCE;
      end
      ST_FORCE: begin
        if (!st_avail || (st_grant && (st_count_d < Full))) state_d = LD_PRI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= LD_PRI;
      starve_q       <= '0;
      out_val_q      <= 1'b0;
      out_is_store_q <= 1'b0;
      out_pkt_q      <= '0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      out_val_q      <= out_val_d;
      out_is_store_q <= out_is_store_d;
      out_pkt_q      <= out_pkt_d;
    end
  end

  assign bus.dmem_req_val      = out_val_q;
  assign bus.dmem_req_packet   = out_pkt_q;
  assign bus.dmem_req_is_store = out_is_store_q;
  assign bus.st_buf_empty      = !st_avail && !out_is_store_q;

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Directed bench for dmem_req_arbiter; DMEM issues are checked in order against a scoreboard.
module tb_dmem_req_arbiter;
  import uarch_pkg::*;

  typedef struct packed {
    logic         is_store;
    instruction_t pkt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  dmem_req_arbiter_if bus ();

  dmem_req_arbiter #(
    .STORE_BUF_DEPTH(4),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic instruction_t mk(input logic [31:0] a, input logic [31:0] d,
                                      input logic [5:0] r);
    instruction_t p;
    p.addr    = a;
    p.data    = d;
    p.rob_idx = r;
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_store, input instruction_t pkt);
    exp_q.push_back({is_store, pkt});
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_dmem_val"},   128'(bus.dmem_req_val),      128'(0));
    check({pfx, "_is_store"},   128'(bus.dmem_req_is_store), 128'(0));
    check({pfx, "_pkt"},        128'(bus.dmem_req_packet),   128'(0));
    check({pfx, "_ld_rdy"},     128'(bus.ld_req_rdy),        128'(0));
    check({pfx, "_st_rdy"},     128'(bus.st_req_rdy),        128'(0));
    check({pfx, "_st_empty"},   128'(bus.st_buf_empty),      128'(1));
  endtask

  // Every DMEM transfer must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t got;
    exp_t want;
    if (bus.dmem_req_val && bus.dmem_req_rdy) begin
      got = {bus.dmem_req_is_store, bus.dmem_req_packet};
      if (exp_q.size() > 0) want = exp_q.pop_front();
      else want = '1;
      check("dmem_issue", 128'(got), 128'(want));
    end
  end

  initial begin
    bus.ld_req_val    = 1'b0;
    bus.ld_req_packet = '0;
    bus.st_req_val    = 1'b0;
    bus.st_req_packet = '0;
    bus.dmem_req_rdy  = 1'b0;
    repeat (2) tick();

    // Reset held with live inputs.
    bus.ld_req_val    = 1'b1;
    bus.st_req_val    = 1'b1;
    bus.ld_req_packet = mk(32'h1, 32'h2, 6'd3);
    bus.st_req_packet = mk(32'h4, 32'h5, 6'd6);
    bus.dmem_req_rdy  = 1'b1;
    #1;
    check_reset("rst");
    tick();
    bus.ld_req_val = 1'b0;
    bus.st_req_val = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_ld_rdy", 128'(bus.ld_req_rdy), 128'(1));
    check("post_rst_st_rdy", 128'(bus.st_req_rdy), 128'(1));

    // Load and store together: load next cycle, store the cycle after.
    bus.ld_req_val    = 1'b1;
    bus.ld_req_packet = mk(32'h100, 32'h0, 6'd1);
    bus.st_req_val    = 1'b1;
    bus.st_req_packet = mk(32'h200, 32'hAAAA, 6'd2);
    push_exp(1'b0, mk(32'h100, 32'h0, 6'd1));
    push_exp(1'b1, mk(32'h200, 32'hAAAA, 6'd2));
    tick();
    bus.ld_req_val = 1'b0;
    bus.st_req_val = 1'b0;
    #1;
    check("a_ld_val",  128'(bus.dmem_req_val),         128'(1));
    check("a_ld_kind", 128'(bus.dmem_req_is_store),    128'(0));
    check("a_ld_pkt",  128'(bus.dmem_req_packet),      128'(mk(32'h100, 32'h0, 6'd1)));
    check("a_cnt",     128'(dut.u_store_buffer.count), 128'(1));
    tick();
    #1;
    check("a_st_val",  128'(bus.dmem_req_val),      128'(1));
    check("a_st_kind", 128'(bus.dmem_req_is_store), 128'(1));
    check("a_st_pkt",  128'(bus.dmem_req_packet),   128'(mk(32'h200, 32'hAAAA, 6'd2)));
    check("a_st_busy", 128'(bus.st_buf_empty),      128'(0));
    tick();
    #1;
    check("a_idle",  128'(bus.dmem_req_val), 128'(0));
    check("a_empty", 128'(bus.st_buf_empty), 128'(1));
    check("a_sb",    128'(exp_q.size()),     128'(0));

    // Continuous loads starve one store for exactly 8 cycles, then it is forced.
    for (int i = 0; i < 10; i++) begin
      bus.ld_req_val    = 1'b1;
      bus.ld_req_packet = mk(32'h1000 + 32'(i), 32'h0, 6'(i));
      bus.st_req_val    = (i == 0);
      bus.st_req_packet = mk(32'h2000, 32'hBEEF, 6'd9);
      #1;
      check("b_ld_rdy", 128'(bus.ld_req_rdy), 128'(i < 9));
      if (i < 9) push_exp(1'b0, mk(32'h1000 + 32'(i), 32'h0, 6'(i)));
      if (i == 9) begin
        check("b_state_force", 128'(dut.state_q), 128'(ST_FORCE));
        push_exp(1'b1, mk(32'h2000, 32'hBEEF, 6'd9));
      end
      tick();
    end
    bus.ld_req_val = 1'b0;
    #1;
    check("b_forced_pkt",  128'(bus.dmem_req_packet),   128'(mk(32'h2000, 32'hBEEF, 6'd9)));
    check("b_forced_kind", 128'(bus.dmem_req_is_store), 128'(1));
    check("b_state_back",  128'(dut.state_q),           128'(LD_PRI));
    tick();
    #1;
    check("b_sb", 128'(exp_q.size()), 128'(0));

    // Fill the buffer behind a stalled load, then drain in push order.
    bus.dmem_req_rdy  = 1'b0;
    bus.ld_req_val    = 1'b1;
    bus.ld_req_packet = mk(32'h3000, 32'h0, 6'd20);
    push_exp(1'b0, mk(32'h3000, 32'h0, 6'd20));
    tick();
    bus.ld_req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.st_req_val    = 1'b1;
      bus.st_req_packet = mk(32'h300 + 32'(i), 32'h50 + 32'(i), 6'(i));
      #1;
      check("c_st_rdy", 128'(bus.st_req_rdy), 128'(1));
      push_exp(1'b1, mk(32'h300 + 32'(i), 32'h50 + 32'(i), 6'(i)));
      tick();
    end
    bus.st_req_packet = mk(32'h999, 32'h999, 6'd63);
    #1;
    check("c_full_rdy", 128'(bus.st_req_rdy),           128'(0));
    check("c_full_cnt", 128'(dut.u_store_buffer.count), 128'(4));
    check("c_state",    128'(dut.state_q),              128'(ST_FORCE));
    check("c_hold_val", 128'(bus.dmem_req_val),         128'(1));
    tick();
    bus.st_req_val = 1'b0;
    #1;
    check("c_stall_pkt", 128'(bus.dmem_req_packet),      128'(mk(32'h3000, 32'h0, 6'd20)));
    check("c_stall_cnt", 128'(dut.u_store_buffer.count), 128'(4));
    bus.dmem_req_rdy = 1'b1;
    tick();
    #1;
    check("c_state_back", 128'(dut.state_q),              128'(LD_PRI));
    check("c_head_pkt",   128'(bus.dmem_req_packet),      128'(mk(32'h300, 32'h50, 6'd0)));
    check("c_cnt3",       128'(dut.u_store_buffer.count), 128'(3));
    repeat (4) tick();
    #1;
    check("c_drained", 128'(bus.st_buf_empty), 128'(1));
    check("c_sb",      128'(exp_q.size()),     128'(0));

    // Flush kills a stalled load but leaves the buffered store alone.
    bus.dmem_req_rdy  = 1'b0;
    bus.ld_req_val    = 1'b1;
    bus.ld_req_packet = mk(32'h4000, 32'h0, 6'd30);
    bus.st_req_val    = 1'b1;
    bus.st_req_packet = mk(32'h4400, 32'h77, 6'd40);
    tick();
    bus.ld_req_val = 1'b0;
    bus.st_req_val = 1'b0;
    #1;
    check("d_ld_held", 128'(bus.dmem_req_val),         128'(1));
    check("d_ld_pkt",  128'(bus.dmem_req_packet),      128'(mk(32'h4000, 32'h0, 6'd30)));
    check("d_cnt",     128'(dut.u_store_buffer.count), 128'(1));
    flush = 1'b1;
    bus.ld_req_val    = 1'b1;
    bus.ld_req_packet = mk(32'h4100, 32'h0, 6'd31);
    tick();
    flush = 1'b0;
    bus.ld_req_val = 1'b0;
    #1;
    check("d_flushed", 128'(bus.dmem_req_val),         128'(0));
    check("d_cnt2",    128'(dut.u_store_buffer.count), 128'(1));
    check("d_st_busy", 128'(bus.st_buf_empty),         128'(0));
    push_exp(1'b1, mk(32'h4400, 32'h77, 6'd40));
    bus.dmem_req_rdy = 1'b1;
    tick();
    #1;
    check("d_st_pkt", 128'(bus.dmem_req_packet), 128'(mk(32'h4400, 32'h77, 6'd40)));
    tick();
    #1;
    check("d_empty", 128'(bus.st_buf_empty), 128'(1));
    flush = 1'b1;
    bus.ld_req_val    = 1'b1;
    bus.ld_req_packet = mk(32'h4200, 32'h0, 6'd32);
    #1;
    check("d_flush_ld_rdy", 128'(bus.ld_req_rdy), 128'(0));
    tick();
    flush = 1'b0;
    bus.ld_req_val = 1'b0;
    #1;
    check("d_no_ld", 128'(bus.dmem_req_val), 128'(0));
    check("d_sb",    128'(exp_q.size()),     128'(0));

    // Reset in the middle of a store drain.
    bus.dmem_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.st_req_val    = 1'b1;
      bus.st_req_packet = mk(32'h500 + 32'(i), 32'h60 + 32'(i), 6'(i));
      #1;
      check("e_st_rdy", 128'(bus.st_req_rdy), 128'(1));
      tick();
    end
    bus.st_req_val = 1'b0;
    push_exp(1'b1, mk(32'h500, 32'h60, 6'd0));
    bus.dmem_req_rdy = 1'b1;
    tick();
    #1;
    check("e_cnt3", 128'(dut.u_store_buffer.count), 128'(3));
    check("e_pkt",  128'(bus.dmem_req_packet),      128'(mk(32'h501, 32'h61, 6'd1)));
    #1;
    rst = 1'b0;
    #1;
    check_reset("e_rst");
    check("e_rst_cnt",   128'(dut.u_store_buffer.count), 128'(0));
    check("e_rst_state", 128'(dut.state_q),              128'(LD_PRI));
    tick();
    rst = 1'b1;
    #1;
    check("e_post_ld_rdy", 128'(bus.ld_req_rdy),   128'(1));
    check("e_post_empty",  128'(bus.st_buf_empty), 128'(1));
    tick();
    #1;
    check("e_post_val", 128'(bus.dmem_req_val), 128'(0));
    check("e_sb",       128'(exp_q.size()),     128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_req_arbiter.md
DMEM_REQ_ARBITER -- requirements
Module: dmem_req_arbiter

Interface
REQ-001 SHALL have parameter STORE_BUF_DEPTH, default 4: committed-store buffer entries; power of two.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: cycles a buffered store may be denied before it is forced.
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, rst asynchronous and active-low.
REQ-004 SHALL have flush (in, 1): pipeline flush; kills in-flight load state only.
REQ-005 SHALL have ld_req_val (in, 1), ld_req_packet (in, instruction_t) and ld_req_rdy (out, 1): load request from the LSQ.
REQ-006 SHALL have st_req_val (in, 1), st_req_packet (in, instruction_t) and st_req_rdy (out, 1): committed store from the LSQ.
REQ-007 SHALL have dmem_req_val (out, 1), dmem_req_packet (out, instruction_t), dmem_req_is_store (out, 1) and dmem_req_rdy (in, 1): the DMEM request port.
REQ-008 SHALL have st_buf_empty (out, 1), true when buffer and output register hold no store, used by the LSQ for fences.

Function
REQ-009 SHALL transfer on any port only on val&&rdy in the same cycle.
REQ-010 SHALL assert st_req_rdy iff the store buffer count is below STORE_BUF_DEPTH.
REQ-011 SHALL accept at most one store per cycle into a FIFO, oldest first; accept and drain in one cycle SHALL leave count unchanged.
REQ-012 SHALL hold the DMEM request in a single output register, so grant-to-dmem_req_val latency is 1 cycle.
REQ-013 SHALL let the output register load when it is empty or (dmem_req_val&&dmem_req_rdy), giving back-to-back issue.
REQ-014 SHALL hold dmem_req_packet and dmem_req_is_store stable while dmem_req_val&&!dmem_req_rdy.
REQ-015 SHALL use FSM states LD_PRI (reset) and ST_FORCE.
REQ-016 SHALL, in LD_PRI, grant a valid load and otherwise the FIFO head store when the output register can load.
REQ-017 SHALL, in ST_FORCE, grant the FIFO head store and deassert ld_req_rdy.
REQ-018 SHALL move LD_PRI->ST_FORCE when the starve counter reaches STARVE_LIMIT or FIFO count equals STORE_BUF_DEPTH.
REQ-019 SHALL move ST_FORCE->LD_PRI after a store grant that leaves the count below STORE_BUF_DEPTH, or when the FIFO is empty.
REQ-020 SHALL increment the starve counter each cycle the FIFO is non-empty and no store is granted, saturating at STARVE_LIMIT.
REQ-021 SHALL clear the starve counter on any store grant or when the FIFO is empty.
REQ-022 SHALL assert ld_req_rdy iff the state is LD_PRI, flush is low and the output register can load.
REQ-023 SHALL, on flush, invalidate an output register holding a load (dmem_req_val low the next cycle), even mid-stall.
REQ-024 SHALL, on flush, grant no load that cycle.
REQ-025 SHALL leave stores in the FIFO or output register, the FSM and the starve counter unaffected by flush.
REQ-026 SHALL let a store present on st_req that cycle not be granted until the following cycle (no FIFO bypass).
REQ-027 SHALL drive st_buf_empty combinationally from the FIFO count and the output register's is_store bit.

Reset
REQ-028 SHALL, while rst is low, force dmem_req_val=0, dmem_req_is_store=0, dmem_req_packet=all-zero, ld_req_rdy=0, st_req_rdy=0 and st_buf_empty=1.
REQ-029 SHALL, while rst is low, clear FIFO pointers and count, set the starve counter to 0 and the FSM to LD_PRI.
REQ-030 SHALL assert ld_req_rdy=1 and st_req_rdy=1 on the first cycle after rst deasserts.
REQ-031 SHALL discard all buffered stores on reset mid-operation, with no partial request left on DMEM.

Structure
REQ-032 SHALL place STORE_BUF_DEPTH and STARVE_LIMIT defaults in uarch_pkg; instruction_t stays in uarch_pkg unchanged.
REQ-033 SHALL implement the FIFO as one sub-module, store_buffer, with push/pop/count/head; FSM, counter and output register stay in dmem_req_arbiter.

Verification
REQ-034 SHALL test: load and store both valid, FIFO count 1, dmem_req_rdy=1 -> load issued cycle+1; store issued cycle+2.
REQ-035 SHALL test: continuous loads, one store buffered -> store forced after exactly 8 denied cycles; ld_req_rdy low that cycle.
REQ-036 SHALL test: 4 stores pushed, dmem_req_rdy=0 -> st_req_rdy low at count 4, state ST_FORCE.
REQ-037 SHALL test (REQ-036 continued): dmem_req_rdy released -> stores drain in push order, then LD_PRI.
REQ-038 SHALL test: load stalled in output register (dmem_req_rdy=0), flush pulse -> dmem_req_val=0 next cycle, FIFO count unchanged.
REQ-039 SHALL test: rst asserted mid-drain with 3 stores buffered -> all outputs at reset values asynchronously; st_buf_empty=1.
